keypad_entry_ctrl: RTL and testbench
====================================

# keypad_entry_ctrl

- Sequences key events from the 4x4 keypad scan decoder into multi-digit decimal entries for the number-guessing game.
- Filters the decoder's per-column `is_pressed` flicker into exactly one event per physical press.
- Supports digit entry, clear, optional backspace, and enter.
- Converts the buffered BCD digits to binary and hands the entry to game logic over a valid/ready handshake.

## Interface
Parameters:
- `MAX_DIGITS`, default 2: maximum decimal digits per entry (1..4).
- `VAL_W`, default 7: binary entry width. Must satisfy 10^MAX_DIGITS − 1 < 2^VAL_W.
- `RELEASE_CYC`, default 500000: number of consecutive cycles with `is_pressed` low before a release is declared. Must exceed one full scan period (400008 cycles).

Ports:
- `clk` input 1: system clock, 50 MHz; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `key_code` input 4: decoder `decode_out`.
- `is_pressed` input 1: decoder `is_pressed`; already synchronous to `clk`.
- `guess_ready` input 1: consumer accepts an entry.
- `guess_valid` output 1: entry available.
- `guess_value` output VAL_W: binary entry; stable while `guess_valid` is high.
- `digits_bcd` output 4*MAX_DIGITS: entered digits, newest in bits [3:0], unused digits 0; drives the display.
- `digit_count` output 3: number of digits currently buffered.
- `key_err` output 1: one-cycle pulse on a rejected key.
- `busy` output 1: high in CONVERT and VALID.

## Operation
Press filter:
- `armed` resets to 0.
- A press event fires on a rising edge of `is_pressed` while `armed`=1. `key_code` is captured in the same cycle, and `armed` is cleared.
- The release counter restarts on every cycle with `is_pressed` high. `armed` sets once `is_pressed` has been low for RELEASE_CYC consecutive cycles.

Key map, applied in ENTRY:
- 0x0–0x9 (digit): shift into `digits_bcd` and increment `digit_count`.
  - If `digit_count`==MAX_DIGITS, the digit is dropped and `key_err` pulses.
- 0xA (enter): go to CONVERT if `digit_count`>0; otherwise `key_err` pulses.
- 0xC (clear): zero the digits and count.
- 0xB (backspace): see Configuration.
- 0xD, 0xE, 0xF: ignored, no error.

FSM states:
- ENTRY: the reset state.
- CONVERT: accumulator starts at 0. One digit is processed per cycle, oldest first: acc = acc*10 + digit, computed in VAL_W bits. After `digit_count` cycles the result is loaded into `guess_value` and the FSM moves to VALID.
- VALID: `guess_valid`=1. When `guess_valid` and `guess_ready` are both high on a clock edge, the FSM returns to ENTRY and the digits and count clear on that edge.

Key events in CONVERT or VALID are consumed (`armed` still clears) and discarded, with no `key_err`.

Reset mid-operation: the asynchronous reset returns the FSM to ENTRY and zeroes every output. A key still held when reset deasserts does not produce an event until it has been released for RELEASE_CYC cycles.

## Timing
- Reset values: `guess_valid`=0, `guess_value`=0, `digits_bcd`=0, `digit_count`=0, `key_err`=0, `busy`=0.
- Key effect latency: `digits_bcd`, `digit_count` and `key_err` update 1 cycle after the `is_pressed` rising edge.
- Enter to `guess_valid` high: 1 + `digit_count` + 1 cycles after the enter edge.
- `guess_ready` high before `guess_valid` is legal and causes a transfer on the first VALID cycle.
- `guess_value` and `busy` hold until the transfer edge. `busy` drops the cycle after the transfer.

## Configuration
Macro `KEYPAD_BACKSPACE_EN`:
- Defined: 0xB in ENTRY removes the newest digit (digits shift toward bit 0, count decrements). Backspace with `digit_count`==0 pulses `key_err`.
- Undefined: 0xB is ignored like 0xD–0xF, and no backspace logic is synthesized.

## Structure
- Package `keypad_pkg` holds:
  - key code constants `KEY_ENTER`=4'hA, `KEY_BKSP`=4'hB, `KEY_CLEAR`=4'hC;
  - the FSM state enum `entry_state_t` (ENTRY, CONVERT, VALID);
  - the scan-period constant 400008.
- One sub-module, `keypad_press_filter`, contains the rising-edge detect, the release counter and `armed`. It outputs `key_evt` (one-cycle pulse) and `key_evt_code`.

## Test plan
All scenarios run with RELEASE_CYC=20.
- Flicker: `is_pressed` toggles 1-high/7-low for 200 cycles with code 5, then stays low 30 cycles → exactly one digit 5 entered; `digit_count`=1.
- Entry: keys 4, 2, A → `guess_valid` rises 4 cycles after the A edge with `guess_value`=42; `guess_ready` held low keeps it valid; a pulse on `guess_ready` clears `digits_bcd` to 0.
- Overflow and empty enter: A with no digits → `key_err` pulse. Keys 9, 9, 7 → 7 rejected with `key_err`, `digits_bcd`=0x99; enter → 99.
- Clear and backspace: keys 3, 8, B, 1 → `digits_bcd`=0x31 with the macro defined, and 0x38 with 1 rejected when undefined; key C → count 0.
- Busy drop: key 6 pressed during VALID → ignored, `guess_value` unchanged.
- Reset: assert `rst_n` low during CONVERT while a key is held → all outputs 0; no event until the key is released for 20 cycles.

Source files
------------

// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared constants and types for the keypad entry controller.
package keypad_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  // Decoder scan period in clk cycles; the release window must be longer.
  localparam int SCAN_PERIOD_CYC = 400008;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CONVERT = 2'd1,
    VALID   = 2'd2
  } entry_state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Guess handoff channel: valid/ready with a binary value.
interface keypad_entry_ctrl_if #(
  parameter int VAL_W = 7
) ();
  logic             guess_valid;
  logic             guess_ready;
  logic [VAL_W-1:0] guess_value;

  modport master (output guess_valid, output guess_value, input  guess_ready);
  modport slave  (input  guess_valid, input  guess_value, output guess_ready);
endinterface

// File: rtl/keypad_entry_ctrl_press_filter.sv
// Turns the flickering decoder is_pressed into one event per physical press.
module keypad_press_filter #(
  parameter int RELEASE_CYC = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       is_pressed,
  output logic       key_evt,
  output logic [3:0] key_evt_code
);
  localparam int CNT_W = (RELEASE_CYC < 1) ? 1 : $clog2(RELEASE_CYC + 1);

  logic             prev;
  logic             armed;
  logic [CNT_W-1:0] rel_cnt;

  assign key_evt      = is_pressed & ~prev & armed;
  assign key_evt_code = key_code;

  // armed starts low so a key held through reset must be released first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= 1'b0;
      armed   <= 1'b0;
      rel_cnt <= '0;
    end else begin
      prev <= is_pressed;
      if (is_pressed)
        rel_cnt <= '0;
      else if (rel_cnt != CNT_W'(RELEASE_CYC))
        rel_cnt <= rel_cnt + CNT_W'(1);
      if (key_evt)
        armed <= 1'b0;
      else if (!is_pressed && rel_cnt == CNT_W'(RELEASE_CYC - 1))
        armed <= 1'b1;
    end
  end
endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad digit entry, BCD-to-binary conversion and guess handoff.
// Optional backspace on key 0xB when KEYPAD_BACKSPACE_EN is defined.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int MAX_DIGITS  = 2,
  parameter int VAL_W       = 7,
  parameter int RELEASE_CYC = 500000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              key_code,
  input  logic                    is_pressed,
  keypad_entry_ctrl_if.master     gif,
  output logic [4*MAX_DIGITS-1:0] digits_bcd,
  output logic [2:0]              digit_count,
  output logic                    key_err,
  output logic                    busy
);
  localparam int DW = 4 * MAX_DIGITS;

  logic             key_evt;
  logic [3:0]       key_evt_code;
  entry_state_t     state;
  logic [DW-1:0]    digits_r;
  logic [2:0]       count_r;
  logic [2:0]       cnv_left;
  logic [VAL_W-1:0] acc;
  logic [VAL_W-1:0] gval;
  logic             gvalid;
  logic [3:0]       cur_dig;
  logic [VAL_W-1:0] acc_nxt;

  keypad_press_filter #(.RELEASE_CYC(RELEASE_CYC)) u_filt (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_code     (key_code),
    .is_pressed   (is_pressed),
    .key_evt      (key_evt),
    .key_evt_code (key_evt_code)
  );

  // Oldest remaining digit sits at position cnv_left-1.
  always_comb begin
    cur_dig = 4'd0;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (3'(i) == cnv_left - 3'd1) cur_dig = digits_r[4*i +: 4];
  end

  assign acc_nxt = (acc << 3) + (acc << 1) + VAL_W'(cur_dig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ENTRY;
      digits_r <= '0;
      count_r  <= '0;
      cnv_left <= '0;
      acc      <= '0;
      gval     <= '0;
      gvalid   <= 1'b0;
      key_err  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      key_err <= 1'b0;
      case (state)
        ENTRY: begin
          if (key_evt) begin
            if (is_digit(key_evt_code)) begin
              if (count_r == 3'(MAX_DIGITS)) begin
                key_err <= 1'b1;
              end else begin
                digits_r <= (digits_r << 4) | DW'(key_evt_code);
                count_r  <= count_r + 3'd1;
              end
            end else if (key_evt_code == KEY_ENTER) begin
              if (count_r == 3'd0) begin
                key_err <= 1'b1;
              end else begin
                state    <= CONVERT;
                busy     <= 1'b1;
                acc      <= '0;
                cnv_left <= count_r;
              end
            end else if (key_evt_code == KEY_CLEAR) begin
              digits_r <= '0;
              count_r  <= '0;
`ifdef KEYPAD_BACKSPACE_EN
            end else if (key_evt_code == KEY_BKSP) begin
              if (count_r == 3'd0) begin
                key_err <= 1'b1;
              end else begin
                digits_r <= digits_r >> 4;
                count_r  <= count_r - 3'd1;
              end
`endif
            end
          end
        end
        CONVERT: begin
          // One extra cycle after the last digit to load the result.
          if (cnv_left != 3'd0) begin
            acc      <= acc_nxt;
            cnv_left <= cnv_left - 3'd1;
          end else begin
            gval   <= acc;
            gvalid <= 1'b1;
            state  <= VALID;
          end
        end
        VALID: begin
          if (gif.guess_ready) begin
            state    <= ENTRY;
            gvalid   <= 1'b0;
            busy     <= 1'b0;
            digits_r <= '0;
            count_r  <= '0;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

  assign gif.guess_valid = gvalid;
  assign gif.guess_value = gval;
  assign digits_bcd      = digits_r;
  assign digit_count     = count_r;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Table-driven key vectors plus a scoreboard on the guess handoff.
module tb_keypad_entry_ctrl;
  import keypad_pkg::*;

  localparam int MD = 2;
  localparam int VW = 7;
  localparam int RC = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    key_code = 4'd0;
  logic          is_pressed = 1'b0;
  logic [4*MD-1:0] digits_bcd;
  logic [2:0]    digit_count;
  logic          key_err;
  logic          busy;

  keypad_entry_ctrl_if #(.VAL_W(VW)) gif ();

  keypad_entry_ctrl #(.MAX_DIGITS(MD), .VAL_W(VW), .RELEASE_CYC(RC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_code    (key_code),
    .is_pressed  (is_pressed),
    .gif         (gif.master),
    .digits_bcd  (digits_bcd),
    .digit_count (digit_count),
    .key_err     (key_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    logic [3:0] code;
    logic [7:0] dig;
    logic [2:0] cnt;
    logic       err;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every transfer must match the oldest queued entry.
  always @(posedge clk) begin
    if (gif.guess_valid === 1'b1 && gif.guess_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: got %0d, expected no transfer", gif.guess_value);
      end else begin
        chk("xfer_value", 32'(gif.guess_value), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] c);
    key_code   = c;
    is_pressed = 1'b1;
    cyc(1);
  endtask

  task automatic release_k();
    is_pressed = 1'b0;
    cyc(RC + 2);
  endtask

  task automatic press_chk(input logic [3:0] c, input logic [7:0] d,
                           input logic [2:0] n, input logic e);
    press(c);
    chk($sformatf("key%h_digits", c), 32'(digits_bcd), 32'(d));
    chk($sformatf("key%h_count", c), 32'(digit_count), 32'(n));
    chk($sformatf("key%h_err", c), 32'(key_err), 32'(e));
    release_k();
  endtask

  initial begin
    tbl[0]  = '{4'hC, 8'h00, 3'd0, 1'b0};
    tbl[1]  = '{4'hA, 8'h00, 3'd0, 1'b1};
    tbl[2]  = '{4'h9, 8'h09, 3'd1, 1'b0};
    tbl[3]  = '{4'h9, 8'h99, 3'd2, 1'b0};
    tbl[4]  = '{4'h7, 8'h99, 3'd2, 1'b1};
    tbl[5]  = '{4'hD, 8'h99, 3'd2, 1'b0};
    tbl[6]  = '{4'hC, 8'h00, 3'd0, 1'b0};
    tbl[7]  = '{4'h3, 8'h03, 3'd1, 1'b0};
    tbl[8]  = '{4'h8, 8'h38, 3'd2, 1'b0};
`ifdef KEYPAD_BACKSPACE_EN
    tbl[9]  = '{4'hB, 8'h03, 3'd1, 1'b0};
    tbl[10] = '{4'h1, 8'h31, 3'd2, 1'b0};
    tbl[11] = '{4'hC, 8'h00, 3'd0, 1'b0};
    tbl[12] = '{4'hB, 8'h00, 3'd0, 1'b1};
`else
    tbl[9]  = '{4'hB, 8'h38, 3'd2, 1'b0};
    tbl[10] = '{4'h1, 8'h38, 3'd2, 1'b1};
    tbl[11] = '{4'hC, 8'h00, 3'd0, 1'b0};
    tbl[12] = '{4'hB, 8'h00, 3'd0, 1'b0};
`endif
    gif.guess_ready = 1'b0;

    cyc(3);
    chk("rst_valid", 32'(gif.guess_valid), 0);
    chk("rst_value", 32'(gif.guess_value), 0);
    chk("rst_digits", 32'(digits_bcd), 0);
    chk("rst_count", 32'(digit_count), 0);
    chk("rst_err", 32'(key_err), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    cyc(RC + 5);

    // Flicker: 1 high / 7 low never re-arms, so only one digit lands.
    for (int i = 0; i < 200; i++) begin
      key_code   = 4'd5;
      is_pressed = (i % 8 == 0);
      cyc(1);
    end
    is_pressed = 1'b0;
    cyc(30);
    chk("flicker_digits", 32'(digits_bcd), 32'h05);
    chk("flicker_count", 32'(digit_count), 1);

    for (int i = 0; i < 13; i++)
      press_chk(tbl[i].code, tbl[i].dig, tbl[i].cnt, tbl[i].err);

    // Entry 42 with enter-to-valid latency.
    press_chk(4'd4, 8'h04, 3'd1, 1'b0);
    press_chk(4'd2, 8'h42, 3'd2, 1'b0);
    exp_q.push_back(42);
    press(KEY_ENTER);
    chk("enter_busy", 32'(busy), 1);
    chk("enter_valid_t1", 32'(gif.guess_valid), 0);
    cyc(2);
    chk("enter_valid_t3", 32'(gif.guess_valid), 0);
    cyc(1);
    chk("enter_valid_t4", 32'(gif.guess_valid), 1);
    chk("enter_value", 32'(gif.guess_value), 42);
    release_k();
    chk("hold_valid", 32'(gif.guess_valid), 1);

    // Key during VALID is discarded silently.
    press(4'd6);
    chk("busy_key_err", 32'(key_err), 0);
    chk("busy_key_digits", 32'(digits_bcd), 32'h42);
    release_k();
    chk("busy_key_value", 32'(gif.guess_value), 42);
    chk("busy_key_valid", 32'(gif.guess_valid), 1);

    gif.guess_ready = 1'b1;
    cyc(1);
    gif.guess_ready = 1'b0;
    chk("xfer_digits", 32'(digits_bcd), 0);
    chk("xfer_count", 32'(digit_count), 0);
    chk("xfer_valid", 32'(gif.guess_valid), 0);
    chk("xfer_busy", 32'(busy), 0);

    // 99 with overflow reject, ready asserted ahead of valid.
    press_chk(4'd9, 8'h09, 3'd1, 1'b0);
    press_chk(4'd9, 8'h99, 3'd2, 1'b0);
    press_chk(4'd7, 8'h99, 3'd2, 1'b1);
    gif.guess_ready = 1'b1;
    exp_q.push_back(99);
    press(KEY_ENTER);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        cyc(1);
        if (gif.guess_valid === 1'b1) seen = 1'b1;
      end
      chk("early_ready_valid_seen", 32'(seen), 1);
    end
    cyc(1);
    gif.guess_ready = 1'b0;
    chk("early_ready_valid_drop", 32'(gif.guess_valid), 0);
    chk("early_ready_count", 32'(digit_count), 0);
    release_k();

    // Reset in CONVERT with the key held through reset.
    press_chk(4'd1, 8'h01, 3'd1, 1'b0);
    press_chk(4'd2, 8'h12, 3'd2, 1'b0);
    press(KEY_ENTER);
    chk("conv_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_digits", 32'(digits_bcd), 0);
    chk("mid_rst_count", 32'(digit_count), 0);
    chk("mid_rst_valid", 32'(gif.guess_valid), 0);
    chk("mid_rst_value", 32'(gif.guess_value), 0);
    chk("mid_rst_err", 32'(key_err), 0);
    cyc(2);
    rst_n    = 1'b1;
    key_code = 4'd3;
    cyc(5);
    chk("held_no_evt", 32'(digit_count), 0);
    is_pressed = 1'b0;
    cyc(10);
    is_pressed = 1'b1;
    cyc(2);
    chk("short_release_no_evt", 32'(digit_count), 0);
    release_k();
    press_chk(4'd3, 8'h03, 3'd1, 1'b0);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
